nios_dbg_sysclk_bridge: RTL and testbench

NIOS_DBG_SYSCLK_BRIDGE -- requirements
Module: nios_dbg_sysclk_bridge

---
 rtl/nios_dbg_sysclk_bridge.sv | 141 ++++++++++++++
 tb/tb_nios_dbg_sysclk_bridge.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_dbg_sysclk_bridge.sv
`default_nettype none
// ============================================================================
// Module   : nios_dbg_sysclk_bridge
// Brief    : Moves JTAG Update-IR/Update-DR events into the system clock
//            domain and presents the captured command with a valid/ready hold.
// Revision : 1.0 - initial release
// ============================================================================
module nios_dbg_sysclk_bridge #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = SR_W - 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [SR_W-1:0]      sr,
    input  logic                 vs_uir_tgl,
    input  logic                 vs_udr_tgl,
    input  logic                 cmd_ready,
    input  logic                 overrun_clr,
    output logic [SR_W-1:0]      jdo,
    output logic [IR_W-1:0]      cmd_ir,
    output logic                 cmd_valid,
    output logic [2**IR_W-1:0]   take_action,
    output logic [2**IR_W-1:0]   take_no_action,
    output logic                 busy,
    output logic                 overrun
);

    localparam int c_NCH = 2**IR_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic                   r_uir_hist;
    logic                   r_udr_hist;
    logic [IR_W-1:0]        r_ir_reg;
    logic [SR_W-1:0]        r_jdo;
    logic [IR_W-1:0]        r_cmd_ir;
    logic                   r_cmd_valid;
    logic [c_NCH-1:0]       r_take_action;
    logic [c_NCH-1:0]       r_take_no_action;
    logic                   r_overrun;
    state_t                 r_state;

    logic                   w_uir_p;
    logic                   w_udr_p;
    logic [c_NCH-1:0]       w_onehot;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_uir_sync <= '0;
            r_udr_sync <= '0;
            r_uir_hist <= 1'b0;
            r_udr_hist <= 1'b0;
        end else begin
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir_tgl};
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr_tgl};
            r_uir_hist <= r_uir_sync[SYNC_STAGES-1];
            r_udr_hist <= r_udr_sync[SYNC_STAGES-1];
        end
    end

    assign w_uir_p  = r_uir_sync[SYNC_STAGES-1] ^ r_uir_hist;
    assign w_udr_p  = r_udr_sync[SYNC_STAGES-1] ^ r_udr_hist;
    assign w_onehot = {{(c_NCH-1){1'b0}}, 1'b1} << r_ir_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir_reg <= '0;
        end else if (w_uir_p) begin
            r_ir_reg <= ir_in;
        end
    end

    // A capture takes the IR value held before any same-cycle IR update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_jdo            <= '0;
            r_cmd_ir         <= '0;
            r_cmd_valid      <= 1'b0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
            r_overrun        <= 1'b0;
        end else begin
            r_take_action    <= '0;
            r_take_no_action <= '0;

            if (w_udr_p && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_udr_p) begin
                        r_jdo       <= sr;
                        r_cmd_ir    <= r_ir_reg;
                        r_cmd_valid <= 1'b1;
                        if (sr[ACT_BIT]) begin
                            r_take_action    <= w_onehot;
                        end else begin
                            r_take_no_action <= w_onehot;
                        end
                        r_state <= S_STROBE;
                    end
                end
                S_STROBE, S_WAIT: begin
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state     <= S_WAIT;
                    end
                end
                default: begin
                    r_cmd_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign jdo            = r_jdo;
    assign cmd_ir         = r_cmd_ir;
    assign cmd_valid      = r_cmd_valid;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign overrun        = r_overrun;
    assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_nios_dbg_sysclk_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_dbg_sysclk_bridge
// Brief    : Directed and randomized checks of the debug sysclk bridge against
//            a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_dbg_sysclk_bridge;

    localparam int SR_W = 38;
    localparam int IR_W = 2;
    localparam int SS   = 2;
    localparam int ACT  = 34;
    localparam int NCH  = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [IR_W-1:0] ir_in = '0;
    logic [SR_W-1:0] sr = '0;
    logic            vs_uir_tgl = 1'b0;
    logic            vs_udr_tgl = 1'b0;
    logic            cmd_ready = 1'b0;
    logic            overrun_clr = 1'b0;
    logic [SR_W-1:0] jdo;
    logic [IR_W-1:0] cmd_ir;
    logic            cmd_valid;
    logic [NCH-1:0]  take_action;
    logic [NCH-1:0]  take_no_action;
    logic            busy;
    logic            overrun;

    nios_dbg_sysclk_bridge #(
        .SR_W        (SR_W),
        .IR_W        (IR_W),
        .SYNC_STAGES (SS),
        .ACT_BIT     (ACT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ir_in          (ir_in),
        .sr             (sr),
        .vs_uir_tgl     (vs_uir_tgl),
        .vs_udr_tgl     (vs_udr_tgl),
        .cmd_ready      (cmd_ready),
        .overrun_clr    (overrun_clr),
        .jdo            (jdo),
        .cmd_ir         (cmd_ir),
        .cmd_valid      (cmd_valid),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: each toggle is an event that takes effect at a known
    // clock edge; the command is either pending (with its first cycle being
    // the strobe cycle) or not.
    typedef struct {
        int              when;
        logic [SR_W-1:0] val;
    } ev_t;

    ev_t             uir_q[$];
    ev_t             udr_q[$];
    int              cyc = 0;
    int              last_uir = -100;
    int              last_udr = -100;
    logic [SR_W-1:0] m_jdo = '0;
    logic [IR_W-1:0] m_cmd_ir = '0;
    logic [IR_W-1:0] m_ir = '0;
    bit              m_pending = 0;
    bit              m_fresh = 0;
    bit              m_ovr = 0;

    task automatic model_reset();
        uir_q.delete();
        udr_q.delete();
        m_jdo = '0; m_cmd_ir = '0; m_ir = '0;
        m_pending = 0; m_fresh = 0; m_ovr = 0;
    endtask

    task automatic model_step();
        ev_t             ev;
        bit              u, i, was_pending;
        logic [SR_W-1:0] uval;
        logic [IR_W-1:0] ival;
        cyc++;
        u = 0; i = 0; uval = '0; ival = '0;
        if (udr_q.size() > 0 && udr_q[0].when == cyc) begin
            ev = udr_q.pop_front(); u = 1; uval = ev.val;
        end
        if (uir_q.size() > 0 && uir_q[0].when == cyc) begin
            ev = uir_q.pop_front(); i = 1; ival = ev.val[IR_W-1:0];
        end
        was_pending = m_pending;
        m_fresh = 0;
        if (was_pending) begin
            if (cmd_ready) m_pending = 0;
        end else if (u) begin
            m_jdo = uval; m_cmd_ir = m_ir; m_pending = 1; m_fresh = 1;
        end
        if (u && was_pending) m_ovr = 1;
        else if (overrun_clr) m_ovr = 0;
        if (i) m_ir = ival;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
    endtask

    task automatic toggle_uir(input logic [IR_W-1:0] v);
        ev_t ev;
        ir_in = v;
        vs_uir_tgl = ~vs_uir_tgl;
        ev.when = cyc + 1 + SS;
        ev.val  = SR_W'(v);
        uir_q.push_back(ev);
        last_uir = cyc;
    endtask

    task automatic toggle_udr(input logic [SR_W-1:0] v);
        ev_t ev;
        sr = v;
        vs_udr_tgl = ~vs_udr_tgl;
        ev.when = cyc + 1 + SS;
        ev.val  = v;
        udr_q.push_back(ev);
        last_udr = cyc;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        tick(); tick();
        vectors++;
        if ({jdo, cmd_ir, cmd_valid, take_action, take_no_action, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_state: got jdo=%h ir=%h v=%b ta=%b tna=%b busy=%b ovr=%b, expected all zero",
                     jdo, cmd_ir, cmd_valid, take_action, take_no_action, busy, overrun);
        end
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_basic_action();
        cmd_ready = 1'b1;
        toggle_uir(2'd2);
        repeat (SS + 3) tick();
        toggle_udr(38'h04_0000_1234);
        repeat (SS) tick();
        vectors++;
        if (take_action !== 4'b0000 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: got ta=%b v=%b, expected ta=0000 v=0", take_action, cmd_valid);
        end
        tick();
        vectors++;
        if (take_action !== 4'b0100 || take_no_action !== 4'b0000) begin
            errors++;
            $display("FAIL basic_strobe: got ta=%b tna=%b, expected ta=0100 tna=0000", take_action, take_no_action);
        end
        vectors++;
        if (jdo !== 38'h04_0000_1234 || cmd_ir !== 2'd2 || cmd_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_data: got jdo=%h ir=%0d v=%b busy=%b, expected jdo=0400001234 ir=2 v=1 busy=1",
                     jdo, cmd_ir, cmd_valid, busy);
        end
        tick();
        vectors++;
        if (take_action !== 4'b0000 || busy !== 1'b0 || cmd_valid !== 1'b0 || jdo !== 38'h04_0000_1234) begin
            errors++;
            $display("FAIL basic_after: got ta=%b busy=%b v=%b jdo=%h, expected ta=0000 busy=0 v=0 jdo=0400001234",
                     take_action, busy, cmd_valid, jdo);
        end
    endtask

    task automatic test_no_action();
        cmd_ready = 1'b1;
        toggle_uir(2'd1);
        repeat (SS + 3) tick();
        toggle_udr(38'h00_DEAD_BEEF);
        repeat (SS + 1) tick();
        vectors++;
        if (take_no_action !== 4'b0010 || take_action !== 4'b0000 || jdo !== 38'h00_DEAD_BEEF) begin
            errors++;
            $display("FAIL no_action: got tna=%b ta=%b jdo=%h, expected tna=0010 ta=0000 jdo=00deadbeef",
                     take_no_action, take_action, jdo);
        end
        tick();
        vectors++;
        if (take_no_action !== 4'b0000) begin
            errors++;
            $display("FAIL no_action_once: got tna=%b, expected 0000", take_no_action);
        end
    endtask

    task automatic test_backpressure();
        int valid_cycles;
        int strobe_cycles;
        valid_cycles = 0;
        strobe_cycles = 0;
        cmd_ready = 1'b0;
        toggle_udr(38'h04_0000_00AA);
        repeat (SS + 1) tick();
        for (int k = 0; k < 6; k++) begin
            if (cmd_valid === 1'b1) valid_cycles++;
            if ((take_action | take_no_action) !== 4'b0000) strobe_cycles++;
            vectors++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_busy: cycle %0d got busy=%b, expected 1", k, busy);
            end
            cmd_ready = (k == 5);
            tick();
        end
        vectors++;
        if (valid_cycles != 6 || strobe_cycles != 1) begin
            errors++;
            $display("FAIL bp_counts: got valid_cycles=%0d strobe_cycles=%0d, expected 6 and 1",
                     valid_cycles, strobe_cycles);
        end
        vectors++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got v=%b busy=%b, expected v=0 busy=0", cmd_valid, busy);
        end
    endtask

    task automatic test_overrun();
        cmd_ready = 1'b0;
        toggle_udr(38'h04_1111_2222);
        repeat (SS + 2) tick();
        toggle_udr(38'h1);
        repeat (SS + 1) tick();
        vectors++;
        if (overrun !== 1'b1 || jdo !== 38'h04_1111_2222 || cmd_valid !== 1'b1 ||
            (take_action | take_no_action) !== 4'b0000) begin
            errors++;
            $display("FAIL overrun_set: got ovr=%b jdo=%h v=%b ta=%b tna=%b, expected ovr=1 jdo=0411112222 v=1 no strobe",
                     overrun, jdo, cmd_valid, take_action, take_no_action);
        end
        cmd_ready = 1'b1;
        tick();
        vectors++;
        if (overrun !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_sticky: got ovr=%b v=%b, expected ovr=1 v=0", overrun, cmd_valid);
        end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got ovr=%b, expected 0", overrun);
        end
    endtask

    task automatic test_simultaneous();
        cmd_ready = 1'b1;
        toggle_uir(2'd0);
        repeat (SS + 3) tick();
        toggle_uir(2'd3);
        toggle_udr(38'h04_0000_0001);
        repeat (SS + 1) tick();
        vectors++;
        if (cmd_ir !== 2'd0 || take_action !== 4'b0001) begin
            errors++;
            $display("FAIL simul_old_ir: got ir=%0d ta=%b, expected ir=0 ta=0001", cmd_ir, take_action);
        end
        repeat (SS + 2) tick();
        toggle_udr(38'h00_0000_0055);
        repeat (SS + 1) tick();
        vectors++;
        if (cmd_ir !== 2'd3 || take_no_action !== 4'b1000) begin
            errors++;
            $display("FAIL simul_new_ir: got ir=%0d tna=%b, expected ir=3 tna=1000", cmd_ir, take_no_action);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        bit stray;
        stray = 0;
        cmd_ready = 1'b0;
        toggle_udr(38'h04_0BAD_F00D);
        repeat (SS + 2) tick();
        toggle_udr(38'h2);
        repeat (SS + 1) tick();
        vectors++;
        if (busy !== 1'b1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_pre: got busy=%b ovr=%b, expected busy=1 ovr=1", busy, overrun);
        end
        reset_n = 1'b0;
        vs_uir_tgl = 1'b0;
        vs_udr_tgl = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (cmd_valid !== 1'b0 || jdo !== '0 || overrun !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_async: got v=%b jdo=%h ovr=%b busy=%b, expected all zero",
                     cmd_valid, jdo, overrun, busy);
        end
        tick();
        reset_n = 1'b1;
        cmd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if ((take_action | take_no_action) !== 4'b0000 || cmd_valid !== 1'b0) stray = 1;
        end
        vectors++;
        if (stray) begin
            errors++;
            $display("FAIL rstwait_after: got a strobe or valid after reset release, expected none");
        end
    endtask

    task automatic test_random();
        logic [63:0]     rnd;
        logic [NCH-1:0]  exp_ta, exp_tna;
        logic [50:0]     act, exp;
        for (int n = 0; n < 1500; n++) begin
            cmd_ready   = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 7) == 0);
            if ((cyc - last_uir) >= SS + 2 && $urandom_range(0, 5) == 0)
                toggle_uir(IR_W'($urandom_range(0, 3)));
            if ((cyc - last_udr) >= SS + 2 && $urandom_range(0, 2) == 0) begin
                rnd = {$urandom, $urandom};
                toggle_udr(rnd[SR_W-1:0]);
            end
            tick();
            exp_ta  = (m_fresh && m_jdo[ACT])  ? (NCH'(1) << m_cmd_ir) : '0;
            exp_tna = (m_fresh && !m_jdo[ACT]) ? (NCH'(1) << m_cmd_ir) : '0;
            act = {jdo, cmd_ir, cmd_valid, take_action, take_no_action, busy, overrun};
            exp = {m_jdo, m_cmd_ir, m_pending, exp_ta, exp_tna, m_pending, m_ovr};
            vectors++;
            if (act !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: got {jdo,ir,v,ta,tna,busy,ovr}=%h, expected %h", n, act, exp);
            end
        end
        overrun_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_action();
        test_no_action();
        test_backpressure();
        test_overrun();
        test_simultaneous();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
